// File: rtl/snake_pkg.sv
// Shared types and screen constants for the snake game blocks.
// Ports: none (package: direction/state enums, coordinate width, grid bounds).
package snake_pkg;

    localparam int COORD_W = 10;
    localparam logic [COORD_W-1:0] PARK_COORD = 10'h3FF;

    localparam int SCR_X_MIN = 8;
    localparam int SCR_X_MAX = 631;
    localparam int SCR_Y_MIN = 8;
    localparam int SCR_Y_MAX = 471;
    localparam int GRID_STEP = 8;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        MOVE,
        CHECK,
        DEAD
    } ctrl_state_t;

    // Opposite directions differ only in bit 0 of the encoding.
    function automatic dir_t opposite_dir(dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

endpackage

// File: rtl/snake_body_ctrl_if.sv
// Food placement handshake between the body controller and the food block.
// Signals: FoodX/FoodY food center, food_req relocate request, food_ack done.
interface snake_body_ctrl_if;
    import snake_pkg::*;

    logic [COORD_W-1:0] FoodX;
    logic [COORD_W-1:0] FoodY;
    logic               food_req;
    logic               food_ack;

    modport master (
        output food_req,
        input  food_ack,
        input  FoodX,
        input  FoodY
    );

    modport slave (
        input  food_req,
        output food_ack,
        output FoodX,
        output FoodY
    );

endinterface

// File: rtl/snake_hit_detect.sv
// Combinational self-collision and food-proximity detection.
// In: slot arrays (slot 0 is the head), length, food center. Out: self_hit, food_hit.
module snake_hit_detect
    import snake_pkg::*;
#(
    parameter int MAX_LEN = 19,
    parameter int LEN_W   = 5,
    parameter int STEP    = GRID_STEP
) (
    input  logic [COORD_W-1:0] slot_x [MAX_LEN],
    input  logic [COORD_W-1:0] slot_y [MAX_LEN],
    input  logic [LEN_W-1:0]   length,
    input  logic [COORD_W-1:0] food_x,
    input  logic [COORD_W-1:0] food_y,
    output logic               self_hit,
    output logic               food_hit
);

    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;

    always_comb begin
        self_hit = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if (LEN_W'(i) < length &&
                slot_x[i] == slot_x[0] &&
                slot_y[i] == slot_y[0])
                self_hit = 1'b1;
        end
    end

    // Absolute distance, ordered so the subtraction never wraps.
    assign dx = (slot_x[0] > food_x) ? slot_x[0] - food_x
                                     : food_x - slot_x[0];
    assign dy = (slot_y[0] > food_y) ? slot_y[0] - food_y
                                     : food_y - slot_y[0];

    assign food_hit = (dx < COORD_W'(STEP)) && (dy < COORD_W'(STEP));

endmodule

// File: rtl/snake_body_ctrl.sv
// Snake segment sequencer: movement, growth, wall/self collision, food request.
// Ports: Clk, Reset (sync, low), start, move_tick, dir_in, food bus, seg_x/seg_y/seg_valid, length, game_over.
module snake_body_ctrl
    import snake_pkg::*;
#(
    parameter int MAX_LEN  = 19,
    parameter int INIT_LEN = 2,
    parameter int STEP     = GRID_STEP,
    parameter int X_MIN    = SCR_X_MIN,
    parameter int X_MAX    = SCR_X_MAX,
    parameter int Y_MIN    = SCR_Y_MIN,
    parameter int Y_MAX    = SCR_Y_MAX,
    parameter int START_X  = 320,
    parameter int START_Y  = 240
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       start,
    input  logic                       move_tick,
    input  logic [1:0]                 dir_in,
    snake_body_ctrl_if.master          food,
    output logic [MAX_LEN*COORD_W-1:0] seg_x,
    output logic [MAX_LEN*COORD_W-1:0] seg_y,
    output logic [MAX_LEN-1:0]         seg_valid,
    output logic [4:0]                 length,
    output logic                       game_over
);

    localparam int LEN_W = 5;
    localparam int XW    = COORD_W + 1;

    ctrl_state_t state;
    ctrl_state_t state_next;

    logic [COORD_W-1:0] slot_x [MAX_LEN];
    logic [COORD_W-1:0] slot_y [MAX_LEN];
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   new_len;
    dir_t               cur_dir;
    dir_t               pending_dir;
    logic               grow_pending;
    logic               food_req_q;
    logic               game_over_q;
    logic               wall_hit;

    logic [COORD_W-1:0] next_x;
    logic [COORD_W-1:0] next_y;
    logic               off_grid;
    logic               self_hit;
    logic               food_hit;
    logic               reinit;
    logic               eat;

    function automatic logic [COORD_W-1:0] init_x(int i);
        return (i < INIT_LEN) ? COORD_W'(START_X - i * STEP) : PARK_COORD;
    endfunction

    function automatic logic [COORD_W-1:0] init_y(int i);
        return (i < INIT_LEN) ? COORD_W'(START_Y) : PARK_COORD;
    endfunction

    snake_hit_detect #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W),
        .STEP    (STEP)
    ) u_hit (
        .slot_x   (slot_x),
        .slot_y   (slot_y),
        .length   (len_q),
        .food_x   (food.FoodX),
        .food_y   (food.FoodY),
        .self_hit (self_hit),
        .food_hit (food_hit)
    );

    always_ff @(posedge Clk) begin
        if (!Reset) state <= IDLE;
        else        state <= state_next;
    end

    // A wall hit is latched in MOVE and acted on in CHECK so that
    // game_over and food_req share the same tick-to-output latency.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (move_tick) state_next = MOVE;
            MOVE:    state_next = CHECK;
            CHECK:   state_next = (wall_hit || self_hit) ? DEAD : RUN;
            DEAD:    if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // Next head follows pending_dir, which becomes cur_dir in MOVE.
    // Edge tests use widened or pre-offset compares to avoid wrap.
    always_comb begin
        next_x   = slot_x[0];
        next_y   = slot_y[0];
        off_grid = 1'b0;
        unique case (pending_dir)
            UP: begin
                if (slot_y[0] < COORD_W'(Y_MIN + STEP)) off_grid = 1'b1;
                else next_y = slot_y[0] - COORD_W'(STEP);
            end
            DOWN: begin
                if ({1'b0, slot_y[0]} + XW'(STEP) > XW'(Y_MAX)) off_grid = 1'b1;
                else next_y = slot_y[0] + COORD_W'(STEP);
            end
            LEFT: begin
                if (slot_x[0] < COORD_W'(X_MIN + STEP)) off_grid = 1'b1;
                else next_x = slot_x[0] - COORD_W'(STEP);
            end
            RIGHT: begin
                if ({1'b0, slot_x[0]} + XW'(STEP) > XW'(X_MAX)) off_grid = 1'b1;
                else next_x = slot_x[0] + COORD_W'(STEP);
            end
            default: ;
        endcase
    end

    assign new_len = (grow_pending && len_q < LEN_W'(MAX_LEN))
                   ? len_q + 1'b1 : len_q;

    // Food is only taken when no request is outstanding, so an ack
    // in the same CHECK cycle still masks that tick's hit.
    assign eat = (state == CHECK) && !wall_hit && !self_hit &&
                 food_hit && !food_req_q;

    assign reinit = !Reset || (state == DEAD && start);

    always_ff @(posedge Clk) begin
        if (reinit) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                slot_x[i] <= init_x(i);
                slot_y[i] <= init_y(i);
            end
            len_q        <= LEN_W'(INIT_LEN);
            cur_dir      <= RIGHT;
            pending_dir  <= RIGHT;
            grow_pending <= 1'b0;
            food_req_q   <= 1'b0;
            game_over_q  <= 1'b0;
            wall_hit     <= 1'b0;
        end else begin
            if (state == RUN && dir_t'(dir_in) != opposite_dir(cur_dir))
                pending_dir <= dir_t'(dir_in);

            if (state == MOVE) begin
                cur_dir  <= pending_dir;
                wall_hit <= off_grid;
                if (!off_grid) begin
                    slot_x[0] <= next_x;
                    slot_y[0] <= next_y;
                    // Shifting into the new tail slot keeps the old tail there.
                    for (int i = 1; i < MAX_LEN; i++) begin
                        if (LEN_W'(i) < new_len) begin
                            slot_x[i] <= slot_x[i-1];
                            slot_y[i] <= slot_y[i-1];
                        end
                    end
                    len_q        <= new_len;
                    grow_pending <= 1'b0;
                end
            end

            if (state == CHECK) game_over_q <= wall_hit || self_hit;

            if (eat) grow_pending <= 1'b1;

            if (food_req_q && food.food_ack) food_req_q <= 1'b0;
            else if (eat)                    food_req_q <= 1'b1;
        end
    end

    assign length        = len_q;
    assign game_over     = game_over_q;
    assign food.food_req = food_req_q;

    for (genvar i = 0; i < MAX_LEN; i++) begin : g_out
        assign seg_valid[i] = LEN_W'(i) < len_q;
        assign seg_x[i*COORD_W +: COORD_W] = seg_valid[i] ? slot_x[i] : PARK_COORD;
        assign seg_y[i*COORD_W +: COORD_W] = seg_valid[i] ? slot_y[i] : PARK_COORD;
    end

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Directed self-checking bench for snake_body_ctrl.
// Drives inputs on the falling edge and samples outputs there too.
module tb_snake_body_ctrl;
    import snake_pkg::*;

    localparam int N = 19;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    logic start = 1'b0;
    logic move_tick = 1'b0;
    logic [1:0] dir_in = 2'd3;
    logic [N*10-1:0] seg_x;
    logic [N*10-1:0] seg_y;
    logic [N-1:0] seg_valid;
    logic [4:0] length;
    logic game_over;

    int checks = 0;
    int errors = 0;

    snake_body_ctrl_if food_bus();

    snake_body_ctrl #(.MAX_LEN(N)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .start     (start),
        .move_tick (move_tick),
        .dir_in    (dir_in),
        .food      (food_bus),
        .seg_x     (seg_x),
        .seg_y     (seg_y),
        .seg_valid (seg_valid),
        .length    (length),
        .game_over (game_over)
    );

    always #5 Clk = ~Clk;

    function automatic logic [9:0] sx(int i);
        return seg_x[i*10 +: 10];
    endfunction

    function automatic logic [9:0] sy(int i);
        return seg_y[i*10 +: 10];
    endfunction

    task automatic step(input logic [1:0] d);
        @(negedge Clk); dir_in = d; move_tick = 1'b1;
        @(negedge Clk); move_tick = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
    endtask

    task automatic pulse_start();
        @(negedge Clk); start = 1'b1;
        @(negedge Clk); start = 1'b0;
    endtask

    task automatic pulse_ack();
        @(negedge Clk); food_bus.food_ack = 1'b1;
        @(negedge Clk); food_bus.food_ack = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        checks++; if (length !== 5'd2) begin errors++; $display("FAIL rst_len: got %0d want 2", length); end
        checks++; if (seg_valid !== 19'h3) begin errors++; $display("FAIL rst_valid: got %h want 00003", seg_valid); end
        checks++; if (sx(0) !== 10'd320 || sy(0) !== 10'd240) begin errors++; $display("FAIL rst_head: got %0d,%0d want 320,240", sx(0), sy(0)); end
        checks++; if (sx(1) !== 10'd312 || sy(1) !== 10'd240) begin errors++; $display("FAIL rst_slot1: got %0d,%0d want 312,240", sx(1), sy(1)); end
        checks++; if (seg_x[N*10-1:20] !== '1 || seg_y[N*10-1:20] !== '1) begin errors++; $display("FAIL rst_park: slot2 got %h want 3ff", sx(2)); end
        checks++; if (food_bus.food_req !== 1'b0 || game_over !== 1'b0) begin errors++; $display("FAIL rst_flags: req %b over %b want 0 0", food_bus.food_req, game_over); end
        step(RIGHT);
        checks++; if (sx(0) !== 10'd320) begin errors++; $display("FAIL idle_tick_drop: got %0d want 320", sx(0)); end
    endtask

    task automatic test_move_right();
        pulse_start();
        repeat (3) step(RIGHT);
        checks++; if (sx(0) !== 10'd344 || sy(0) !== 10'd240) begin errors++; $display("FAIL move_head: got %0d,%0d want 344,240", sx(0), sy(0)); end
        checks++; if (sx(1) !== 10'd336 || sy(1) !== 10'd240) begin errors++; $display("FAIL move_slot1: got %0d,%0d want 336,240", sx(1), sy(1)); end
        checks++; if (length !== 5'd2) begin errors++; $display("FAIL move_len: got %0d want 2", length); end
        checks++; if (seg_x[N*10-1:20] !== '1) begin errors++; $display("FAIL move_park: slot2 got %h want 3ff", sx(2)); end
    endtask

    task automatic test_reversal();
        step(LEFT);
        checks++; if (sx(0) !== 10'd352 || sy(0) !== 10'd240) begin errors++; $display("FAIL rev_drop: got %0d,%0d want 352,240", sx(0), sy(0)); end
        step(UP);
        checks++; if (sx(0) !== 10'd352 || sy(0) !== 10'd232) begin errors++; $display("FAIL turn_up: got %0d,%0d want 352,232", sx(0), sy(0)); end
        checks++; if (sx(1) !== 10'd352 || sy(1) !== 10'd240) begin errors++; $display("FAIL turn_slot1: got %0d,%0d want 352,240", sx(1), sy(1)); end
    endtask

    task automatic test_food();
        food_bus.FoodX = 10'd360;
        food_bus.FoodY = 10'd232;
        @(negedge Clk); dir_in = RIGHT; move_tick = 1'b1;
        @(negedge Clk); move_tick = 1'b0;
        @(negedge Clk);
        checks++; if (sx(0) !== 10'd360 || food_bus.food_req !== 1'b0) begin errors++; $display("FAIL food_t2: head %0d req %b want 360 0", sx(0), food_bus.food_req); end
        @(negedge Clk);
        checks++; if (food_bus.food_req !== 1'b1 || length !== 5'd2) begin errors++; $display("FAIL food_t3: req %b len %0d want 1 2", food_bus.food_req, length); end
        repeat (4) @(negedge Clk);
        checks++; if (food_bus.food_req !== 1'b1) begin errors++; $display("FAIL food_hold: req %b want 1", food_bus.food_req); end
        food_bus.FoodX = 10'd100;
        food_bus.FoodY = 10'd100;
        step(RIGHT);
        checks++; if (length !== 5'd3) begin errors++; $display("FAIL grow_len: got %0d want 3", length); end
        checks++; if (sx(2) !== 10'd352 || sy(2) !== 10'd232) begin errors++; $display("FAIL grow_tail: got %0d,%0d want 352,232", sx(2), sy(2)); end
        checks++; if (sx(0) !== 10'd368 || sx(1) !== 10'd360) begin errors++; $display("FAIL grow_body: got %0d,%0d want 368,360", sx(0), sx(1)); end
        pulse_ack();
        checks++; if (food_bus.food_req !== 1'b0) begin errors++; $display("FAIL ack_clear: req %b want 0", food_bus.food_req); end
    endtask

    task automatic test_wall();
        repeat (32) step(RIGHT);
        checks++; if (sx(0) !== 10'd624 || game_over !== 1'b0) begin errors++; $display("FAIL wall_edge: head %0d over %b want 624 0", sx(0), game_over); end
        @(negedge Clk); move_tick = 1'b1;
        @(negedge Clk); move_tick = 1'b0;
        @(negedge Clk);
        checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL wall_t2: over %b want 0", game_over); end
        @(negedge Clk);
        checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL wall_t3: over %b want 1", game_over); end
        checks++; if (sx(0) !== 10'd624 || sx(1) !== 10'd616 || sx(2) !== 10'd608) begin errors++; $display("FAIL wall_frozen: got %0d,%0d,%0d want 624,616,608", sx(0), sx(1), sx(2)); end
        step(RIGHT);
        checks++; if (sx(0) !== 10'd624 || game_over !== 1'b1) begin errors++; $display("FAIL dead_tick_drop: head %0d over %b want 624 1", sx(0), game_over); end
        pulse_start();
        checks++; if (length !== 5'd2 || sx(0) !== 10'd320 || sx(1) !== 10'd312 || sx(2) !== 10'h3FF) begin errors++; $display("FAIL restart: len %0d head %0d s1 %0d s2 %h", length, sx(0), sx(1), sx(2)); end
        checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL restart_over: got %b want 0", game_over); end
        step(RIGHT);
        checks++; if (sx(0) !== 10'd328) begin errors++; $display("FAIL restart_run: got %0d want 328", sx(0)); end
    endtask

    task automatic test_self_hit();
        for (int k = 0; k < 3; k++) begin
            food_bus.FoodX = 10'(336 + 8 * k);
            food_bus.FoodY = 10'd240;
            step(RIGHT);
            checks++; if (food_bus.food_req !== 1'b1) begin errors++; $display("FAIL self_eat%0d: req %b want 1", k, food_bus.food_req); end
            pulse_ack();
        end
        food_bus.FoodX = 10'd100;
        food_bus.FoodY = 10'd100;
        step(RIGHT);
        checks++; if (length !== 5'd5 || sx(0) !== 10'd360 || sx(4) !== 10'd328) begin errors++; $display("FAIL len5: len %0d head %0d tail %0d", length, sx(0), sx(4)); end
        step(UP);
        step(LEFT);
        checks++; if (sx(0) !== 10'd352 || sy(0) !== 10'd232) begin errors++; $display("FAIL coil: got %0d,%0d want 352,232", sx(0), sy(0)); end
        food_bus.FoodX = 10'd352;
        food_bus.FoodY = 10'd240;
        step(DOWN);
        checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL self_over: got %b want 1", game_over); end
        checks++; if (food_bus.food_req !== 1'b0) begin errors++; $display("FAIL self_no_eat: req %b want 0", food_bus.food_req); end
        checks++; if (sx(0) !== 10'd352 || sy(0) !== 10'd240 || length !== 5'd5) begin errors++; $display("FAIL self_head: %0d,%0d len %0d", sx(0), sy(0), length); end
    endtask

    task automatic test_max_len();
        pulse_start();
        for (int k = 1; k <= 19; k++) begin
            food_bus.FoodX = 10'(320 + 8 * k);
            food_bus.FoodY = 10'd240;
            step(RIGHT);
            if (k == 18) begin
                checks++; if (length !== 5'd19) begin errors++; $display("FAIL max_reach: got %0d want 19", length); end
            end
            if (k < 19) pulse_ack();
        end
        checks++; if (length !== 5'd19 || seg_valid !== '1) begin errors++; $display("FAIL max_sat: len %0d valid %h", length, seg_valid); end
        checks++; if (sx(0) !== 10'd472 || sx(18) !== 10'd328) begin errors++; $display("FAIL max_body: head %0d tail %0d want 472 328", sx(0), sx(18)); end
        checks++; if (food_bus.food_req !== 1'b1) begin errors++; $display("FAIL max_req: got %b want 1", food_bus.food_req); end
    endtask

    task automatic test_reset_in_check();
        food_bus.FoodX = 10'd100;
        food_bus.FoodY = 10'd100;
        @(negedge Clk); move_tick = 1'b1;
        @(negedge Clk); move_tick = 1'b0;
        @(negedge Clk);
        checks++; if (sx(0) !== 10'd480) begin errors++; $display("FAIL pre_reset_head: got %0d want 480", sx(0)); end
        Reset = 1'b0;
        @(negedge Clk);
        checks++; if (length !== 5'd2 || seg_valid !== 19'h3) begin errors++; $display("FAIL mid_rst_len: len %0d valid %h", length, seg_valid); end
        checks++; if (sx(0) !== 10'd320 || sx(1) !== 10'd312 || sx(2) !== 10'h3FF) begin errors++; $display("FAIL mid_rst_slots: %0d %0d %h", sx(0), sx(1), sx(2)); end
        checks++; if (food_bus.food_req !== 1'b0 || game_over !== 1'b0) begin errors++; $display("FAIL mid_rst_flags: req %b over %b", food_bus.food_req, game_over); end
        Reset = 1'b1;
        step(RIGHT);
        checks++; if (sx(0) !== 10'd320) begin errors++; $display("FAIL post_rst_idle: got %0d want 320", sx(0)); end
    endtask

    initial begin
        food_bus.FoodX = 10'd100;
        food_bus.FoodY = 10'd100;
        food_bus.food_ack = 1'b0;
        test_reset();
        test_move_right();
        test_reversal();
        test_food();
        test_wall();
        test_self_hit();
        test_max_len();
        test_reset_in_check();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/snake_body_ctrl.md
# snake_body_ctrl

Sequencing controller for the snake's segment positions. It owns the head and body coordinate registers that feed the VGA color mapper's ball/segment inputs and advances the snake one grid step per move tick. It applies direction input with reversal rejection, grows the body when food is eaten, and detects wall and self collisions. It also runs a request/acknowledge handshake with the food placement block.

## Interface
Parameters:
- MAX_LEN, 19: segment slots, including the head (slot 0).
- INIT_LEN, 2: active length after reset or restart. Must satisfy 1 ≤ INIT_LEN ≤ MAX_LEN.
- STEP, 8: grid pitch in pixels per move.
- X_MIN / X_MAX, 8 / 631: inclusive legal head X range.
- Y_MIN / Y_MAX, 8 / 471: inclusive legal head Y range.
- START_X / START_Y, 320 / 240: head position after reset. START_X − (INIT_LEN−1)·STEP ≥ X_MIN.

Ports:
- Clk, in, 1: system clock. Single clock domain.
- Reset, in, 1: synchronous, active-low reset.
- start, in, 1: one-cycle pulse. Leaves IDLE or DEAD.
- move_tick, in, 1: one-cycle pulse from the frame-rate divider.
- dir_in, in, 2: requested direction. 0=up, 1=down, 2=left, 3=right.
- FoodX / FoodY, in, 10: current food center.
- food_ack, in, 1: food block has placed new food.
- seg_x / seg_y, out, MAX_LEN·10: flattened coordinates. Slot i occupies bits [10i+9:10i].
- seg_valid, out, MAX_LEN: per-slot active mask.
- length, out, 5: active segment count.
- food_req, out, 1: level signal. Asks the food block to relocate.
- game_over, out, 1: high while in DEAD.

## Operation
States: IDLE, RUN, MOVE, CHECK, DEAD.
- IDLE: on start go to RUN. Body regs are held.
- RUN: on move_tick go to MOVE. dir_in is sampled here every cycle into pending_dir.
  - pending_dir updates only if it is not the exact opposite of cur_dir. Reversal requests are dropped.
- MOVE:
  - cur_dir ← pending_dir.
  - Compute next head = head ± STEP on the axis of cur_dir.
  - If next head is outside [X_MIN,X_MAX]×[Y_MIN,Y_MAX], go to DEAD with segments unchanged. Compute the left/up edge as head < MIN+STEP so there is no unsigned underflow.
  - Otherwise shift all slots: slot[i] ← slot[i−1], slot[0] ← next head. Go to CHECK.
  - If grow_pending and length < MAX_LEN: length ← length+1, clear grow_pending. The newly valid slot holds the old tail coordinate.
- CHECK:
  - Self-hit: head equals any active slot 1..length−1 exactly. Go to DEAD.
  - Otherwise food hit: |head−Food| < STEP on both axes, and food_req is low. Set grow_pending and food_req. Go to RUN.
  - Self-hit takes priority over eating.
- DEAD: game_over=1. On start, reinitialise exactly as reset, then go to RUN.
- food_req handshake: food_req stays high until a cycle with food_ack=1, then clears the next cycle. food_ack with food_req low is ignored. Food hits while food_req is high are ignored.
- Growth at length == MAX_LEN: grow_pending clears with no length change (saturates).
- Output masking: inactive slots drive seg_x = seg_y = 10'h3FF. seg_valid[i] = (i < length).

## Timing
- Reset values:
  - State IDLE, length = INIT_LEN, cur_dir = pending_dir = right.
  - Slot i < INIT_LEN = (START_X − i·STEP, START_Y).
  - Internal inactive slots are 10'h3FF.
  - food_req = 0, game_over = 0, grow_pending = 0.
- All outputs are registered. move_tick seen in RUN at cycle t:
  - New coordinates are visible at t+2.
  - food_req or game_over is visible at t+3.
  - Back in RUN at t+3.
- move_tick or start arriving outside the state that consumes it is dropped, not queued.
- Reset low in any state overrides everything on the next edge, including mid-handshake. food_req clears.
- food_ack and a new food hit in the same CHECK cycle: the ack clears food_req first. The hit is ignored for that tick.

## Structure
- Package snake_pkg holds:
  - dir_t enum (UP, DOWN, LEFT, RIGHT).
  - ctrl_state_t enum.
  - COORD_W = 10 and PARK_COORD = 10'h3FF.
  - Shared screen-bound constants, reused by the food block and the color mapper.
- One sub-module, snake_hit_detect: combinational. Takes head, slot arrays, length and food coordinates. Returns self_hit and food_hit.
- Coordinates are stored internally as unpacked arrays and flattened only at the ports.

## Test plan
- Reset, then start, then 3 move_ticks with dir_in=right → head X 320→344. Slot 1 = (336,240). length = 2. seg_x slots 2..18 = 0x3FF.
- With cur_dir = right, assert dir_in = left and tick → head still moves right by 8. Then dir_in = up and tick → head Y decreases by 8.
- Set FoodX/FoodY = head + (8,0), then tick:
  - food_req rises at t+3 and stays high until food_ack.
  - The next tick makes length 3, with slot 2 = previous tail.
- Move the head rightward to X = 624, then tick → game_over at t+3 with segments frozen. A start pulse restores the reset coordinates and returns to RUN.
- Grow to length 5, then issue up, left, down ticks to enter slot 3 → game_over. Place food at the collision point as well and confirm food_req stays low.
- Grow to MAX_LEN = 19, then eat once more → length stays 19. Pulse Reset low during the CHECK state → all reset values appear on the next edge.
